viterbi_traceback: RTL and testbench
====================================

# viterbi_traceback

Consumer of the Viterbi forward pass's final-column probabilities and backpointer memory. It runs after the forward decoder has written the per-word backpointers (previous best POS per word/state) and the last word's path probabilities. It selects the best final state, walks the backpointers from the last word to word 0, and streams one POS tag per word over a valid/ready interface. It sits between the backpointer/probability RAMs and the tag output consumer.

## Interface
- N_STATES, 4, number of POS tags (≥2)
- STATE_W, 2, tag index width, ≥ clog2(N_STATES)
- MAX_WORDS, 8, maximum sentence length
- WORD_W, 3, word index width, ≥ clog2(MAX_WORDS)
- PROB_W, 16, unsigned probability width
- BP_AW, 5, backpointer address width, ≥ clog2(MAX_WORDS*N_STATES)

- clk  in  1  sole clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- start  in  1  begin traceback (sampled in IDLE only)
- num_words  in  WORD_W+1  sentence length T
- prob_ren  out  1  final-column probability read strobe
- prob_raddr  out  STATE_W  state index to read
- prob_rdata  in  PROB_W  data valid the cycle after prob_ren
- bp_ren  out  1  backpointer read strobe
- bp_raddr  out  BP_AW  word_idx*N_STATES + state
- bp_rdata  in  STATE_W  previous-word state, valid the cycle after bp_ren
- tag_valid  out  1  tag output valid
- tag_ready  in  1  consumer accepts tag
- tag  out  STATE_W  POS tag
- tag_word  out  WORD_W  word index of tag
- busy  out  1  traceback in progress
- done  out  1  one-cycle completion pulse

## Operation
- States: IDLE, SCAN, SCAN_LAST, EMIT, LOAD, DONE.
- IDLE: start=1 latches T = min(num_words, MAX_WORDS). T=0 goes directly to DONE with no tags. Otherwise go to SCAN.
- SCAN: N_STATES cycles. prob_ren=1 and prob_raddr = 0,1,…,N_STATES-1. Each returned prob_rdata is compared against the running best. The candidate replaces the best only when strictly greater, so ties keep the lowest index. The first returned value always loads.
- SCAN_LAST: compares the final returned value. Sets cur = argmax and idx = T-1, then goes to EMIT.
- EMIT: tag_valid=1, tag=cur, tag_word=idx. Both are held stable until tag_ready.
  - On handshake with idx=0: go to DONE.
  - On handshake with idx>0: in the same cycle drive bp_ren=1 and bp_raddr = idx*N_STATES + cur (from registers), then go to LOAD.
- LOAD: cur ← bp_rdata, idx ← idx-1, go to EMIT.
- DONE: done=1 for one cycle, then go to IDLE.
- busy=1 in every state except IDLE.
- start is ignored while busy.
- Tags are emitted in reverse word order (T-1 down to 0).
- prob_ren and bp_ren are never asserted in the same cycle.
- Probability compare is unsigned, PROB_W bits, with no arithmetic on the data.
- Reset (async, any state): state=IDLE, cur=0, idx=0, best=0. All outputs 0: prob_ren, prob_raddr, bp_ren, bp_raddr, tag_valid, tag, tag_word, busy, done. Reset mid-traceback aborts with no done pulse.

## Timing
- Let c0 be the cycle start is sampled in IDLE.
- c1..cN: SCAN, with prob_ren high each cycle.
- cN+1: SCAN_LAST.
- cN+2: first tag_valid.
- With tag_ready held high, successive tags are 2 cycles apart (EMIT, LOAD).
- Total for T≥1 with ready high: last handshake at cN+2+2(T-1), done on the following cycle, IDLE one cycle later.
- tag_ready low stalls in EMIT indefinitely. No read is issued while stalled.
- T=0: DONE at c1, busy high for c1 only.

## Test plan
- N_STATES=4, T=3, probs [5,9,9,2], bp(2,1)=3, bp(1,3)=0, ready=1 → tags (word2,1),(word1,3),(word0,0); first tag_valid at c6; done at c11; exactly 2 bp reads, at addrs 9 and 7.
- num_words=0 → no prob or bp reads, no tag_valid, done pulse at c1, busy high one cycle.
- T=1, probs [1,1,1,1] → single tag (word0,0) by tie rule; no bp read; done follows handshake.
- T=3 as in the first case, tag_ready held low 5 cycles on each tag → tag/tag_word stable while stalled, same tag sequence, bp_ren only on handshake cycles.
- num_words=12 with MAX_WORDS=8 → clamped to T=8: 8 tags, word 7 down to 0.
- reset_n low during LOAD, then start with T=2 → all outputs 0 during reset, no done for the aborted run, new run completes correctly; start pulsed while busy has no effect.

Source files
------------

// File: rtl/viterbi_traceback.sv
// Viterbi traceback: picks the best final state from the last column of
// probabilities, then walks backpointers from word T-1 down to 0 and streams tags.
module viterbi_traceback #(
  parameter int unsigned N_STATES  = 4,
  parameter int unsigned STATE_W   = 2,
  parameter int unsigned MAX_WORDS = 8,
  parameter int unsigned WORD_W    = 3,
  parameter int unsigned PROB_W    = 16,
  parameter int unsigned BP_AW     = 5
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               start,
  input  logic [WORD_W:0]    num_words,
  output logic               prob_ren,
  output logic [STATE_W-1:0] prob_raddr,
  input  logic [PROB_W-1:0]  prob_rdata,
  output logic               bp_ren,
  output logic [BP_AW-1:0]   bp_raddr,
  input  logic [STATE_W-1:0] bp_rdata,
  output logic               tag_valid,
  input  logic               tag_ready,
  output logic [STATE_W-1:0] tag,
  output logic [WORD_W-1:0]  tag_word,
  output logic               busy,
  output logic               done
);

  typedef enum logic [2:0] {
    S_IDLE, S_SCAN, S_SCAN_LAST, S_EMIT, S_LOAD, S_DONE
  } state_t;

  state_t              r_state, w_next;
  logic [STATE_W-1:0]  r_cnt, r_cur, r_best_idx;
  logic [WORD_W-1:0]   r_idx;
  logic [WORD_W:0]     r_t;
  logic [PROB_W-1:0]   r_best;
  logic [WORD_W:0]     w_t;
  logic                w_cnt_last;

  assign w_t        = (num_words > (WORD_W+1)'(MAX_WORDS)) ? (WORD_W+1)'(MAX_WORDS) : num_words;
  assign w_cnt_last = (r_cnt == STATE_W'(N_STATES - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  // Next state and outputs; bp_ren is issued on the EMIT handshake cycle itself.
  always_comb begin
    w_next     = r_state;
    prob_ren   = 1'b0;
    prob_raddr = '0;
    bp_ren     = 1'b0;
    bp_raddr   = '0;
    tag_valid  = 1'b0;
    tag        = '0;
    tag_word   = '0;
    busy       = 1'b1;
    done       = 1'b0;
    case (r_state)
      S_IDLE: begin
        busy = 1'b0;
        if (start) w_next = (w_t == '0) ? S_DONE : S_SCAN;
      end
      S_SCAN: begin
        prob_ren   = 1'b1;
        prob_raddr = r_cnt;
        if (w_cnt_last) w_next = S_SCAN_LAST;
      end
      S_SCAN_LAST: w_next = S_EMIT;
      S_EMIT: begin
        tag_valid = 1'b1;
        tag       = r_cur;
        tag_word  = r_idx;
        if (tag_ready) begin
          if (r_idx == '0) begin
            w_next = S_DONE;
          end else begin
            bp_ren   = 1'b1;
            bp_raddr = BP_AW'(r_idx) * BP_AW'(N_STATES) + BP_AW'(r_cur);
            w_next   = S_LOAD;
          end
        end
      end
      S_LOAD: w_next = S_EMIT;
      S_DONE: begin
        done   = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Datapath: read data lags the address by one cycle, so SCAN compares entry r_cnt-1.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt      <= '0;
      r_cur      <= '0;
      r_idx      <= '0;
      r_t        <= '0;
      r_best     <= '0;
      r_best_idx <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_t   <= w_t;
            r_cnt <= '0;
          end
        end
        S_SCAN: begin
          r_cnt <= w_cnt_last ? '0 : r_cnt + STATE_W'(1);
          if (r_cnt != '0 && (r_cnt == STATE_W'(1) || prob_rdata > r_best)) begin
            r_best     <= prob_rdata;
            r_best_idx <= r_cnt - STATE_W'(1);
          end
        end
        S_SCAN_LAST: begin
          r_cur <= (prob_rdata > r_best) ? STATE_W'(N_STATES - 1) : r_best_idx;
          r_idx <= WORD_W'(r_t - (WORD_W+1)'(1));
        end
        S_LOAD: begin
          r_cur <= bp_rdata;
          r_idx <= r_idx - WORD_W'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_viterbi_traceback.sv
// Directed bench for viterbi_traceback with RAM models and a cycle-accurate monitor.
module tb_viterbi_traceback;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic [3:0]  num_words;
  logic        prob_ren;
  logic [1:0]  prob_raddr;
  logic [15:0] prob_rdata;
  logic        bp_ren;
  logic [4:0]  bp_raddr;
  logic [1:0]  bp_rdata;
  logic        tag_valid;
  logic        tag_ready;
  logic [1:0]  tag;
  logic [2:0]  tag_word;
  logic        busy;
  logic        done;

  viterbi_traceback dut (
    .clk(clk), .reset_n(reset_n), .start(start), .num_words(num_words),
    .prob_ren(prob_ren), .prob_raddr(prob_raddr), .prob_rdata(prob_rdata),
    .bp_ren(bp_ren), .bp_raddr(bp_raddr), .bp_rdata(bp_rdata),
    .tag_valid(tag_valid), .tag_ready(tag_ready), .tag(tag), .tag_word(tag_word),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  logic [15:0] prob_mem [4];
  logic [1:0]  bp_mem [32];

  always @(posedge clk) begin
    if (prob_ren) prob_rdata <= prob_mem[prob_raddr];
    if (bp_ren)   bp_rdata   <= bp_mem[bp_raddr];
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, obs, exp);
    end
  endtask

  // Cycle bookkeeping: rel is the cycle number relative to c0 (start sampled).
  int cyc = 0;
  int t0  = 0;
  always @(posedge clk) cyc++;

  bit stall_mode = 0;
  int stall_cnt  = 0;
  always @(posedge clk) begin
    #1;
    if (!stall_mode) begin
      tag_ready = 1'b1;
      stall_cnt = 0;
    end else if (tag_valid) begin
      if (stall_cnt < 5) begin
        tag_ready = 1'b0;
        stall_cnt++;
      end else begin
        tag_ready = 1'b1;
        stall_cnt = 0;
      end
    end else begin
      tag_ready = 1'b0;
      stall_cnt = 0;
    end
  end

  bit running = 0;
  int prob_cnt, both_cnt, busy_cnt, done_cnt, done_cyc, first_valid;
  int bad_bp, hold_bad, hold_seen;
  bit hold_valid;
  int held;
  int q_tag[$], q_word[$], q_hs[$], q_bp[$], q_paddr[$];

  task automatic clear_mon();
    prob_cnt = 0; both_cnt = 0; busy_cnt = 0; done_cnt = 0; done_cyc = -1;
    first_valid = -1; bad_bp = 0; hold_bad = 0; hold_seen = 0; hold_valid = 0; held = 0;
    q_tag.delete(); q_word.delete(); q_hs.delete(); q_bp.delete(); q_paddr.delete();
  endtask

  always @(negedge clk) begin
    if (running) begin
      if (prob_ren) begin prob_cnt++; q_paddr.push_back(int'(prob_raddr)); end
      if (prob_ren && bp_ren) both_cnt++;
      if (bp_ren) begin
        q_bp.push_back(int'(bp_raddr));
        if (!tag_ready) bad_bp++;
      end
      if (busy) busy_cnt++;
      if (done) begin done_cnt++; done_cyc = cyc - t0; end
      if (tag_valid) begin
        if (first_valid < 0) first_valid = cyc - t0;
        if (hold_valid) begin
          hold_seen++;
          if (int'({tag, tag_word}) != held) hold_bad++;
        end
        held       = int'({tag, tag_word});
        hold_valid = !tag_ready;
        if (tag_ready) begin
          q_tag.push_back(int'(tag));
          q_word.push_back(int'(tag_word));
          q_hs.push_back(cyc - t0);
        end
      end else begin
        hold_valid = 0;
      end
    end
  end

  task automatic start_run(input logic [3:0] nw);
    clear_mon();
    running = 1;
    @(posedge clk); #1;
    num_words = nw;
    start     = 1'b1;
    t0        = cyc;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    while (done_cnt == 0 && n < 300) begin
      @(posedge clk);
      n++;
    end
    if (done_cnt == 0) check({name, "_timeout"}, 0, 1);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check({name, "_idle_busy"}, int'(busy), 0);
  endtask

  task automatic check_tags(input string name, input int tags[], input int words[]);
    check({name, "_ntags"}, q_tag.size(), tags.size());
    for (int i = 0; i < tags.size() && i < q_tag.size(); i++) begin
      check($sformatf("%s_tag%0d", name, i), q_tag[i], tags[i]);
      check($sformatf("%s_word%0d", name, i), q_word[i], words[i]);
    end
  endtask

  function automatic int outs_or();
    return int'({prob_ren, prob_raddr, bp_ren, bp_raddr, tag_valid, tag, tag_word, busy, done});
  endfunction

  initial begin
    reset_n = 1'b0; start = 1'b0; num_words = '0; tag_ready = 1'b1;
    for (int i = 0; i < 32; i++) bp_mem[i] = '0;
    prob_mem[0] = 16'd5; prob_mem[1] = 16'd9; prob_mem[2] = 16'd9; prob_mem[3] = 16'd2;
    repeat (2) @(negedge clk);
    check("reset_outputs", outs_or(), 0);
    @(posedge clk); #1 reset_n = 1'b1;

    // T=3 baseline
    bp_mem[9] = 2'd3; bp_mem[7] = 2'd0;
    start_run(4'd3);
    wait_done("t3");
    check_tags("t3", '{1, 3, 0}, '{2, 1, 0});
    check("t3_first_valid", first_valid, 6);
    if (q_hs.size() == 3) begin
      check("t3_hs0", q_hs[0], 6);
      check("t3_hs2", q_hs[2], 10);
    end else check("t3_hs_count", q_hs.size(), 3);
    check("t3_done_cyc", done_cyc, 11);
    check("t3_done_cnt", done_cnt, 1);
    check("t3_busy_cycles", busy_cnt, 11);
    check("t3_prob_reads", prob_cnt, 4);
    if (q_paddr.size() == 4) check("t3_paddr3", q_paddr[3], 3);
    check("t3_bp_reads", q_bp.size(), 2);
    if (q_bp.size() == 2) begin
      check("t3_bp_addr0", q_bp[0], 9);
      check("t3_bp_addr1", q_bp[1], 7);
    end
    check("t3_both_ren", both_cnt, 0);

    // T=0
    start_run(4'd0);
    wait_done("t0");
    check("t0_prob_reads", prob_cnt, 0);
    check("t0_bp_reads", q_bp.size(), 0);
    check("t0_valid", first_valid, -1);
    check("t0_done_cyc", done_cyc, 1);
    check("t0_busy_cycles", busy_cnt, 1);

    // T=1 with all-equal probabilities: lowest index wins
    for (int i = 0; i < 4; i++) prob_mem[i] = 16'd1;
    start_run(4'd1);
    wait_done("t1");
    check_tags("t1", '{0}, '{0});
    check("t1_bp_reads", q_bp.size(), 0);
    check("t1_done_cyc", done_cyc, 7);

    // T=3 with 5-cycle stalls on every tag
    prob_mem[0] = 16'd5; prob_mem[1] = 16'd9; prob_mem[2] = 16'd9; prob_mem[3] = 16'd2;
    stall_mode = 1;
    start_run(4'd3);
    wait_done("stall");
    stall_mode = 0;
    check_tags("stall", '{1, 3, 0}, '{2, 1, 0});
    check("stall_hold_bad", hold_bad, 0);
    check("stall_hold_seen", hold_seen, 15);
    check("stall_bp_not_ready", bad_bp, 0);
    check("stall_bp_reads", q_bp.size(), 2);

    // num_words=12 clamps to 8; last column favours state 2 (later tie at 3 loses)
    prob_mem[0] = 16'd3; prob_mem[1] = 16'd1; prob_mem[2] = 16'hF000; prob_mem[3] = 16'hF000;
    for (int i = 0; i < 32; i++) bp_mem[i] = 2'((i % 4) + 1);
    start_run(4'd12);
    wait_done("clamp");
    check_tags("clamp", '{2, 3, 0, 1, 2, 3, 0, 1}, '{7, 6, 5, 4, 3, 2, 1, 0});
    check("clamp_done_cyc", done_cyc, 21);

    // Reset during LOAD, then a fresh T=2 run with an ignored start while busy
    prob_mem[0] = 16'd5; prob_mem[1] = 16'd9; prob_mem[2] = 16'd9; prob_mem[3] = 16'd2;
    bp_mem[5] = 2'd2;
    start_run(4'd2);
    begin
      int n = 0;
      while (q_bp.size() == 0 && n < 50) begin @(negedge clk); n++; end
    end
    check("abort_bp_seen", q_bp.size(), 1);
    @(posedge clk); #1 reset_n = 1'b0;
    @(negedge clk);
    check("abort_reset_outputs", outs_or(), 0);
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    repeat (3) @(negedge clk);
    check("abort_no_done", done_cnt, 0);
    check("abort_idle", int'(busy), 0);

    start_run(4'd2);
    @(posedge clk); @(posedge clk); #1;
    num_words = 4'd5; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    num_words = 4'd2;
    wait_done("rerun");
    check_tags("rerun", '{1, 2}, '{1, 0});
    check("rerun_done_cnt", done_cnt, 1);
    check("rerun_done_cyc", done_cyc, 9);
    check("rerun_busy_cycles", busy_cnt, 9);
    check("rerun_bp_reads", q_bp.size(), 1);
    if (q_bp.size() == 1) check("rerun_bp_addr", q_bp[0], 5);

    running = 0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
